// File: rtl/program_counter_unit_pkg.sv
// Shared types and defaults for the program counter unit and its call-depth tracker.
// The default widths match the instruction stack instance.
package program_counter_unit_pkg;

  localparam int unsigned PCU_ADDR_WIDTH = 4;
  localparam int unsigned PCU_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_RET_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } pcu_state_e;

  // Encoded so that a higher value means a higher priority.
  typedef enum logic [1:0] {
    REQ_INC  = 2'd0,
    REQ_JUMP = 2'd1,
    REQ_CALL = 2'd2,
    REQ_RTRN = 2'd3
  } pcu_req_e;

  function automatic pcu_req_e pcu_pick_req(input logic rtrn, input logic call, input logic jump);
    if (rtrn) begin
      return REQ_RTRN;
    end else if (call) begin
      return REQ_CALL;
    end else if (jump) begin
      return REQ_JUMP;
    end
    return REQ_INC;
  endfunction

endpackage

// File: rtl/program_counter_unit_call_depth_counter.sv
// Call nesting depth counter: gates stack push/pop strobes and detects and latches
// overflow/underflow so that the stack is never driven past its limits.
module program_counter_unit_call_depth_counter
  import program_counter_unit_pkg::*;
#(
  parameter int unsigned addr_width = PCU_ADDR_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                active,
  input  pcu_req_e            req,
  output logic                push_ok,
  output logic                pop_ok,
  output logic                overflow_hit,
  output logic                underflow_hit,
  output logic [addr_width:0] depth,
  output logic                overflow,
  output logic                underflow
);

  localparam logic [addr_width:0] DepthFull = {1'b1, {addr_width{1'b0}}};
  localparam logic [addr_width:0] DepthOne  = {{addr_width{1'b0}}, 1'b1};

  logic [addr_width:0] depth_q, depth_d;
  logic                overflow_q, underflow_q;
  logic                full, empty;

  assign full  = (depth_q == DepthFull);
  assign empty = (depth_q == '0);

  always_comb begin
    push_ok       = 1'b0;
    pop_ok        = 1'b0;
    overflow_hit  = 1'b0;
    underflow_hit = 1'b0;
    if (active) begin
      unique case (req)
        REQ_CALL: begin
          push_ok      = !full;
          overflow_hit = full;
        end
        REQ_RTRN: begin
          pop_ok        = !empty;
          underflow_hit = empty;
        end
        default: ;
      endcase
    end

    depth_d = depth_q;
    if (push_ok) begin
      depth_d = depth_q + DepthOne;
    end else if (pop_ok) begin
      depth_d = depth_q - DepthOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      depth_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      depth_q     <= depth_d;
      overflow_q  <= overflow_q | overflow_hit;
      underflow_q <= underflow_q | underflow_hit;
    end
  end

  assign depth     = depth_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: rtl/program_counter_unit.sv
// Fetch-address sequencer: holds the PC, applies increment/jump/call/return updates and
// drives the instruction stack's push/pop strobes, trapping stack misuse into FAULT.
module program_counter_unit
  import program_counter_unit_pkg::*;
#(
  parameter int unsigned          addr_width = PCU_ADDR_WIDTH,
  parameter int unsigned          data_width = PCU_DATA_WIDTH,
  parameter logic [data_width-1:0] RESET_VEC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_jump,
  input  logic                  i_call,
  input  logic                  i_rtrn,
  input  logic [data_width-1:0] i_target,
  input  logic [data_width-1:0] i_Stack,
  output logic [data_width-1:0] o_PC,
  output logic                  o_call,
  output logic                  o_rtrn,
  output logic                  o_valid,
  output logic [addr_width:0]   o_depth,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  pcu_state_e            state_q;
  logic [data_width-1:0] pc_q;
  logic                  valid_q;

  logic     active;
  pcu_req_e req;
  logic     push_ok, pop_ok;
  logic     overflow_hit, underflow_hit;

  assign active = (state_q == ST_RUN) && i_en;
  assign req    = pcu_pick_req(i_rtrn, i_call, i_jump);

  program_counter_unit_call_depth_counter #(
    .addr_width(addr_width)
  ) u_depth (
    .clk          (clk),
    .rst          (rst),
    .active       (active),
    .req          (req),
    .push_ok      (push_ok),
    .pop_ok       (pop_ok),
    .overflow_hit (overflow_hit),
    .underflow_hit(underflow_hit),
    .depth        (o_depth),
    .overflow     (o_overflow),
    .underflow    (o_underflow)
  );

  // Strobes are combinational so the stack acts on the same edge as the PC update.
  assign o_call  = push_ok;
  assign o_rtrn  = pop_ok;
  assign o_PC    = pc_q;
  assign o_valid = valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_VEC;
      valid_q <= 1'b1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (i_en) begin
            unique case (req)
              REQ_RTRN: begin
                // PC is held; the popped return address arrives after this edge.
                state_q <= underflow_hit ? ST_FAULT : ST_RET_WAIT;
                valid_q <= 1'b0;
              end
              REQ_CALL: begin
                if (overflow_hit) begin
                  state_q <= ST_FAULT;
                  valid_q <= 1'b0;
                end else begin
                  pc_q <= i_target;
                end
              end
              REQ_JUMP: pc_q <= i_target;
              default:  pc_q <= pc_q + data_width'(1);
            endcase
          end
        end
        ST_RET_WAIT: begin
          pc_q    <= i_Stack;
          state_q <= ST_RUN;
          valid_q <= 1'b1;
        end
        ST_FAULT: ;
        default: begin
          state_q <= ST_FAULT;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  a_strobes_exclusive : assert property (@(posedge clk) disable iff (rst) !(o_call && o_rtrn));
  a_valid_tracks_run  : assert property (@(posedge clk) disable iff (rst)
                                         o_valid == (state_q == ST_RUN));

endmodule

// File: tb/tb_program_counter_unit.sv
// Randomized and directed checking of program_counter_unit against a behavioural model,
// with a queue-based instruction stack attached to the DUT's strobes.
module tb_program_counter_unit;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned MaxDepth = 16;
  localparam logic [DW-1:0] ResetVec = 16'h0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_en = 1'b0, i_jump = 1'b0, i_call = 1'b0, i_rtrn = 1'b0;
  logic [DW-1:0] i_target = '0;
  logic [DW-1:0] i_Stack = '0;
  logic [DW-1:0] o_PC;
  logic          o_call, o_rtrn, o_valid, o_overflow, o_underflow;
  logic [AW:0]   o_depth;

  int n_checks = 0;
  int n_errors = 0;

  program_counter_unit #(
    .addr_width(AW),
    .data_width(DW),
    .RESET_VEC (ResetVec)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_en       (i_en),
    .i_jump     (i_jump),
    .i_call     (i_call),
    .i_rtrn     (i_rtrn),
    .i_target   (i_target),
    .i_Stack    (i_Stack),
    .o_PC       (o_PC),
    .o_call     (o_call),
    .o_rtrn     (o_rtrn),
    .o_valid    (o_valid),
    .o_depth    (o_depth),
    .o_overflow (o_overflow),
    .o_underflow(o_underflow)
  );

  always #5 clk = ~clk;

  // Instruction stack: stores the call address, returns stored+1 after the pop edge.
  logic [DW-1:0] stk[$];
  always @(posedge clk) begin
    if (rst) begin
      stk.delete();
    end else begin
      if (o_call && stk.size() < MaxDepth) stk.push_back(o_PC);
      if (o_rtrn && stk.size() > 0) i_Stack <= stk.pop_back() + 16'd1;
    end
  end

  // Reference model: 0 = running, 1 = waiting for return address, 2 = trapped.
  int            m_state = 0;
  logic [DW-1:0] m_pc = ResetVec;
  logic [DW-1:0] m_ret = '0;
  logic [DW-1:0] m_stk[$];
  bit            m_ovf = 0, m_unf = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic exp_call, exp_rtrn;
    exp_call = (m_state == 0) && i_en && i_call && !i_rtrn && (m_stk.size() < MaxDepth);
    exp_rtrn = (m_state == 0) && i_en && i_rtrn && (m_stk.size() > 0);
    check("pc", 32'(o_PC), 32'(m_pc));
    check("valid", 32'(o_valid), 32'(m_state == 0));
    check("depth", 32'(o_depth), 32'(m_stk.size()));
    check("overflow", 32'(o_overflow), 32'(m_ovf));
    check("underflow", 32'(o_underflow), 32'(m_unf));
    check("o_call", 32'(o_call), 32'(exp_call));
    check("o_rtrn", 32'(o_rtrn), 32'(exp_rtrn));
  endtask

  task automatic model_edge();
    if (rst) begin
      m_state = 0;
      m_pc    = ResetVec;
      m_stk.delete();
      m_ovf   = 0;
      m_unf   = 0;
    end else if (m_state == 0) begin
      if (i_en) begin
        if (i_rtrn) begin
          if (m_stk.size() > 0) begin
            m_ret   = m_stk.pop_back() + 16'd1;
            m_state = 1;
          end else begin
            m_unf   = 1;
            m_state = 2;
          end
        end else if (i_call) begin
          if (m_stk.size() < MaxDepth) begin
            m_stk.push_back(m_pc);
            m_pc = i_target;
          end else begin
            m_ovf   = 1;
            m_state = 2;
          end
        end else if (i_jump) begin
          m_pc = i_target;
        end else begin
          m_pc = m_pc + 16'd1;
        end
      end
    end else if (m_state == 1) begin
      m_pc    = m_ret;
      m_state = 0;
    end
  endtask

  // One clock: drive, check settled outputs, advance, return at the next falling edge.
  task automatic step(input logic r, input logic e, input logic j, input logic c,
                      input logic rt, input logic [DW-1:0] tgt);
    rst = r; i_en = e; i_jump = j; i_call = c; i_rtrn = rt; i_target = tgt;
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Initial reset before the model is trusted.
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // 1: sequential fetch from reset.
    do_reset();
    repeat (4) idle();
    check("t1_pc", 32'(o_PC), 32'h0004);

    // 2: single call/return.
    repeat (6) idle();
    check("t2_pc_a", 32'(o_PC), 32'h000A);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0040);
    check("t2_call_pc", 32'(o_PC), 32'h0040);
    check("t2_depth1", 32'(o_depth), 32'd1);
    repeat (2) idle();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0);
    check("t2_bubble", 32'(o_valid), 32'd0);
    idle();
    check("t2_ret_pc", 32'(o_PC), 32'h000B);
    check("t2_depth0", 32'(o_depth), 32'd0);

    // 3: nine nested calls then nine returns.
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0010);
    for (int k = 1; k <= 9; k++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'((k + 1) * 16));
    check("t3_depth9", 32'(o_depth), 32'd9);
    for (int k = 9; k >= 1; k--) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0);
      idle();
      check("t3_ret_pc", 32'(o_PC), 32'(k * 16 + 1));
    end
    check("t3_depth0", 32'(o_depth), 32'd0);

    // 4: overflow trap and recovery.
    do_reset();
    for (int k = 0; k < 16; k++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'(16'h0100 + k));
    check("t4_depth16", 32'(o_depth), 32'd16);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0777);
    check("t4_ovf", 32'(o_overflow), 32'd1);
    check("t4_valid", 32'(o_valid), 32'd0);
    check("t4_pc", 32'(o_PC), 32'h010F);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1234);
    idle();
    check("t4_frozen", 32'(o_PC), 32'h010F);
    do_reset();
    check("t4_rst_pc", 32'(o_PC), 32'(ResetVec));
    check("t4_rst_ovf", 32'(o_overflow), 32'd0);

    // 5: underflow trap, then all requests at once at depth 1.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0);
    check("t5_unf", 32'(o_underflow), 32'd1);
    check("t5_valid", 32'(o_valid), 32'd0);
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0300);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0500);
    check("t5_retwait", 32'(o_valid), 32'd0);
    idle();
    check("t5_ret_pc", 32'(o_PC), 32'h0001);

    // 6: stall, wrap, reset inside the return bubble.
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0ABC);
    check("t6_stall", 32'(o_PC), 32'h0001);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF);
    idle();
    check("t6_wrap", 32'(o_PC), 32'h0000);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0050);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0);
    do_reset();
    check("t6_rst_pc", 32'(o_PC), 32'(ResetVec));
    check("t6_rst_valid", 32'(o_valid), 32'd1);
    check("t6_rst_depth", 32'(o_depth), 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 2500; n++) begin
      step(1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 99) < 88),
           1'($urandom_range(0, 99) < 10), 1'($urandom_range(0, 99) < 22),
           1'($urandom_range(0, 99) < 15), 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
